// File: rtl/event_enc4.sv
// rtl/event_enc4.sv - registered 4-input event encoder with valid/ack output handshake
//
// Captures events on four input lines into a pending set and presents them one
// at a time as a 2-bit index to a single consumer.
//
// Parameters:
//   INV_MASK  bit n set => input I<n> is active-low
//   EDGE      1: event = rising edge of effective input; 0: level (every CE cycle)
//
// Ports:
//   C    in   clock, rising edge
//   CLR  in   asynchronous active-high reset
//   CE   in   clock enable for input sampling (handshake ignores CE)
//   I0   in   event input 0
//   I1   in   event input 1
//   I2   in   event input 2
//   I3   in   event input 3
//   ACK  in   consumer accepts O while VLD=1
//   O    out  encoded index of presented event
//   VLD  out  O holds a valid event
//   OVF  out  sticky: an edge event was lost
//
// Build option:
//   EVENT_ENC4_ROUND_ROBIN_EN  defined: round-robin selection starting after the
//                              last index presented; undefined: lowest index wins.

module event_enc4 #(
  parameter logic [3:0] INV_MASK = 4'b0001,
  parameter bit         EDGE     = 1'b1
) (
  input  logic       C,
  input  logic       CLR,
  input  logic       CE,
  input  logic       I0,
  input  logic       I1,
  input  logic       I2,
  input  logic       I3,
  input  logic       ACK,
  output logic [1:0] O,
  output logic       VLD,
  output logic       OVF
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state;
  logic [3:0] prev;
  logic [3:0] pend;
  logic [3:0] eff;
  logic [3:0] evt;
  logic [3:0] sel_mask;
  logic [3:0] lost;
  logic [1:0] sel;
  logic       load;

  assign eff = {I3, I2, I1, I0} ^ INV_MASK;

  // Events only exist on CE cycles; prev is updated on the same cycles, so a
  // line that rose while CE was low still produces an edge once CE returns.
  always_comb begin
    evt = 4'b0000;
    if (CE) begin
      evt = EDGE ? (eff & ~prev) : eff;
    end
  end

`ifdef EVENT_ENC4_ROUND_ROBIN_EN
  logic [1:0] last;
  logic [1:0] rr_idx;

  // Walk offsets from far to near so the index closest after 'last' wins.
  always_comb begin
    sel    = 2'd0;
    rr_idx = 2'd0;
    for (int n = 3; n >= 0; n--) begin
      rr_idx = last + 2'(n) + 2'd1;
      if (pend[rr_idx]) begin
        sel = rr_idx;
      end
    end
  end
`else
  // Walk downward so the lowest pending index wins.
  always_comb begin
    sel = 2'd0;
    for (int n = 3; n >= 0; n--) begin
      if (pend[n]) begin
        sel = 2'(n);
      end
    end
  end
`endif

  assign load     = ((state == IDLE) || ACK) && (|pend);
  assign sel_mask = load ? (4'b0001 << sel) : 4'b0000;

  // A repeat edge on a line that is still pending is a lost event, unless that
  // line is being handed to the consumer on this very edge.
  assign lost     = EDGE ? (evt & pend & ~sel_mask) : 4'b0000;

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state <= IDLE;
      O     <= 2'b00;
      OVF   <= 1'b0;
      pend  <= 4'b0000;
      prev  <= 4'b0000;
`ifdef EVENT_ENC4_ROUND_ROBIN_EN
      last  <= 2'b11;
`endif
    end else begin
      if (CE) begin
        prev <= eff;
      end

      // New event on the selected line re-arms it (event wins over clear).
      pend <= (pend & ~sel_mask) | evt;

      if (|lost) begin
        OVF <= 1'b1;
      end

      if (load) begin
        O <= sel;
`ifdef EVENT_ENC4_ROUND_ROBIN_EN
        last <= sel;
`endif
      end

      case (state)
        IDLE: begin
          if (load) begin
            state <= PRESENT;
          end
        end
        PRESENT: begin
          if (ACK && !load) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign VLD = (state == PRESENT);

endmodule
